picomips_ctrl_fsm: RTL
======================

Name: picomips_ctrl_fsm

Overview:
Parametrised, sequential successor to the picoMIPS combinational instruction decoder. It decodes the top OPW instruction bits and ALU flags into PC, ALU, immediate-mux and register-file controls. It adds multi-cycle multiply sequencing, a wait-for-switch instruction, the full BEQ/BNE/BGE/BLO branch set, and sticky illegal-opcode reporting. It sits between program ROM output and the PC/ALU/regs datapath.

Parameters:
OPW, 6, opcode width in bits (>= ALUW+3)
ALUW, 3, ALU function width; ALUfunc = opcode[ALUW-1:0]
NFLAGS, 4, flag vector width (>= 4): C=[0], Z=[1], N=[2], V=[3]
MUL_LAT, 4, multiply latency in cycles (>= 1)

Ports:
clk  in  1  system clock
nReset  in  1  asynchronous active-low reset
opcode  in  OPW  top bits of current instruction
flags  in  NFLAGS  ALU flags from the previous instruction
sw8  in  1  raw (asynchronous) user switch for WAITSW
PCincr  out  1  PC increments
PCabsbranch  out  1  PC loads absolute target
PCrelbranch  out  1  PC adds relative offset
ALUfunc  out  ALUW  ALU operation select
imm  out  1  select immediate operand
w1  out  1  write destination register
w2  out  1  store strobe
mul_start  out  1  one-cycle multiplier launch pulse
stall  out  1  held high while the instruction is not retiring
illegal  out  1  sticky: an unimplemented opcode was decoded

Behaviour:
- Reset (nReset low, async): state=RUN, counter=0, sw8 synchroniser=00, illegal=0. While nReset is low, all outputs except ALUfunc are forced to 0, including PCincr.
- States: RUN, MUL_WAIT, SW_PRESS, SW_RELEASE.
- RUN default outputs: PCincr=1, other controls 0, ALUfunc=opcode[ALUW-1:0].
- RUN decode:
  - ADD/SUB: w1=1.
  - ADDI/SUBI/LDI: w1=1, imm=1.
  - STR: w2=1.
  - J: PCincr=0, PCabsbranch=1.
  - BEQ takes if Z=1; BNE if Z=0; BGE if N=0; BLO if C=1. Taken branch: PCincr=0, PCrelbranch=1. Not taken: NOP.
  - NOP: defaults.
  - Any other opcode: executes as NOP; illegal<=1 on the next edge and stays 1 until reset.
- MULL_INT/MULL_FLT with MUL_LAT=1: w1=1 and PCincr=1 in the same RUN cycle, mul_start=1, no stall.
- MULL_INT/MULL_FLT with MUL_LAT>1:
  - RUN cycle: mul_start=1, stall=1, PCincr=0, w1=0; counter<=MUL_LAT-2; next state MUL_WAIT.
  - MUL_WAIT: stall=1, PCincr=0. Counter decrements each cycle. When counter=0: w1=1, PCincr=1, stall=0; next state RUN.
  - Total retire latency is MUL_LAT cycles from issue.
- WAITSW:
  - sw8 passes through a 2-flop synchroniser to give sw8_s.
  - RUN cycle: stall=1, PCincr=0; next state SW_PRESS.
  - SW_PRESS: stall=1; go to SW_RELEASE when sw8_s=1.
  - SW_RELEASE: stall=1; when sw8_s=0, PCincr=1, stall=0, next state RUN.
  - A switch already held when WAITSW issues still requires a release.
- In non-RUN states, opcode and flags are ignored. No illegal detection, no branches, w2=0.
- mul_start is never high outside RUN.
- Outputs are combinational from state, opcode and flags; state, counter, synchroniser and illegal are registered.

Decomposition:
- Package picomips_pkg holds:
  - opcode localparams NOP=00, ADD=01, SUB=02, ADDI=09, SUBI=0A, LDI=0F, J=10, STR=18, MULL_INT=20, MULL_FLT=21, BEQ=30, BNE=31, BGE=32, BLO=33, WAITSW=38 (hex);
  - flag index constants;
  - state enum ctrl_state_t.
- Sub-module sync2 (2-flop synchroniser, async active-low reset) instantiated for sw8.

Test Plan:
- nReset=0 with opcode=ADD (01) -> w1=0, PCincr=0, illegal=0. Release reset -> w1=1, PCincr=1.
- BEQ (30), flags=4'b0010 -> PCrelbranch=1, PCincr=0. flags=4'b0000 -> PCincr=1, PCrelbranch=0. BLO (33), flags=4'b0001 -> PCrelbranch=1. BGE (32), flags=4'b0100 -> not taken.
- MULL_INT (20), MUL_LAT=4 -> mul_start high in cycle 0 only; stall=1 in cycles 0-2; w1=1, PCincr=1 in cycle 3; back to RUN in cycle 4. With MUL_LAT=1 -> w1, PCincr and mul_start all in cycle 0.
- WAITSW (38), sw8 low 5 cycles, high 6, low -> stall stays high; PCincr=1 exactly once, 2-3 cycles after the sw8 fall.
- opcode 3F -> PCincr=1, illegal=1 from the next edge. Then opcode NOP -> illegal remains 1 until nReset pulse.
- Assert nReset low mid-MUL_WAIT (counter=1) -> outputs zero immediately. After release -> RUN, next MULL restarts full latency.

Source files
------------

// File: rtl/picomips_pkg.sv
// picomips_pkg: shared definitions for the picoMIPS control path.
//   - opcode values (top instruction bits), as plain integers so each user
//     can size them to its own opcode width
//   - flag bit positions within the ALU flag vector
//   - ctrl_state_t: sequencing states of picomips_ctrl_fsm
package picomips_pkg;

    // Opcodes (hex)
    localparam int NOP      = 'h00;
    localparam int ADD      = 'h01;
    localparam int SUB      = 'h02;
    localparam int ADDI     = 'h09;
    localparam int SUBI     = 'h0A;
    localparam int LDI      = 'h0F;
    localparam int J        = 'h10;
    localparam int STR      = 'h18;
    localparam int MULL_INT = 'h20;
    localparam int MULL_FLT = 'h21;
    localparam int BEQ      = 'h30;
    localparam int BNE      = 'h31;
    localparam int BGE      = 'h32;
    localparam int BLO      = 'h33;
    localparam int WAITSW   = 'h38;

    // Flag bit positions
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MUL_WAIT   = 2'd1,
        SW_PRESS   = 2'd2,
        SW_RELEASE = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser for a single asynchronous input.
//   clk   in  sampling clock
//   rst_n in  asynchronous active-low reset (clears both stages)
//   d     in  asynchronous input
//   q     out synchronised output, two clk edges behind d
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/picomips_ctrl_fsm.sv
// picomips_ctrl_fsm: sequential instruction decoder for picoMIPS.
// Decodes the current opcode and the previous instruction's ALU flags into
// PC / ALU / immediate-mux / register-file controls, and sequences the
// multi-cycle instructions (multiply, wait-for-switch).
//   clk         in  system clock
//   nReset      in  asynchronous active-low reset
//   opcode      in  [OPW]    top bits of current instruction
//   flags       in  [NFLAGS] ALU flags (C,Z,N,V at bits 0..3)
//   sw8         in  raw user switch, synchronised internally
//   PCincr      out PC increments
//   PCabsbranch out PC loads absolute target
//   PCrelbranch out PC adds relative offset
//   ALUfunc     out [ALUW] ALU operation (low opcode bits)
//   imm         out immediate operand select
//   w1          out register write enable
//   w2          out store strobe
//   mul_start   out one-cycle multiplier launch
//   stall       out instruction not retiring this cycle
//   illegal     out sticky unimplemented-opcode indicator
module picomips_ctrl_fsm #(
    parameter int OPW     = 6,
    parameter int ALUW    = 3,
    parameter int NFLAGS  = 4,
    parameter int MUL_LAT = 4
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic [OPW-1:0]    opcode,
    input  logic [NFLAGS-1:0] flags,
    input  logic              sw8,
    output logic              PCincr,
    output logic              PCabsbranch,
    output logic              PCrelbranch,
    output logic [ALUW-1:0]   ALUfunc,
    output logic              imm,
    output logic              w1,
    output logic              w2,
    output logic              mul_start,
    output logic              stall,
    output logic              illegal
);

    import picomips_pkg::*;

    // Counter only needs to hold MUL_LAT-2
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    localparam logic [OPW-1:0] OP_NOP      = OPW'(NOP);
    localparam logic [OPW-1:0] OP_ADD      = OPW'(ADD);
    localparam logic [OPW-1:0] OP_SUB      = OPW'(SUB);
    localparam logic [OPW-1:0] OP_ADDI     = OPW'(ADDI);
    localparam logic [OPW-1:0] OP_SUBI     = OPW'(SUBI);
    localparam logic [OPW-1:0] OP_LDI      = OPW'(LDI);
    localparam logic [OPW-1:0] OP_J        = OPW'(J);
    localparam logic [OPW-1:0] OP_STR      = OPW'(STR);
    localparam logic [OPW-1:0] OP_MULL_INT = OPW'(MULL_INT);
    localparam logic [OPW-1:0] OP_MULL_FLT = OPW'(MULL_FLT);
    localparam logic [OPW-1:0] OP_BEQ      = OPW'(BEQ);
    localparam logic [OPW-1:0] OP_BNE      = OPW'(BNE);
    localparam logic [OPW-1:0] OP_BGE      = OPW'(BGE);
    localparam logic [OPW-1:0] OP_BLO      = OPW'(BLO);
    localparam logic [OPW-1:0] OP_WAITSW   = OPW'(WAITSW);

    ctrl_state_t   state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          ill_q, ill_set;
    logic          sw8_s;

    // Raw controls before reset gating
    logic incr_c, abs_c, rel_c, imm_c, w1_c, w2_c, ms_c, stall_c;

    // V flag and any extra flag bits are not used by this branch set
    logic unused_flags;
    assign unused_flags = ^flags;

    sync2 u_sync_sw8 (
        .clk   (clk),
        .rst_n (nReset),
        .d     (sw8),
        .q     (sw8_s)
    );

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state <= RUN;
            cnt   <= '0;
            ill_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ill_q <= ill_q | ill_set;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ill_set   = 1'b0;
        incr_c    = 1'b0;
        abs_c     = 1'b0;
        rel_c     = 1'b0;
        imm_c     = 1'b0;
        w1_c      = 1'b0;
        w2_c      = 1'b0;
        ms_c      = 1'b0;
        stall_c   = 1'b0;

        case (state)
            RUN: begin
                incr_c = 1'b1;
                case (opcode)
                    OP_NOP: ;
                    OP_ADD, OP_SUB: w1_c = 1'b1;
                    OP_ADDI, OP_SUBI, OP_LDI: begin
                        w1_c  = 1'b1;
                        imm_c = 1'b1;
                    end
                    OP_STR: w2_c = 1'b1;
                    OP_J: begin
                        incr_c = 1'b0;
                        abs_c  = 1'b1;
                    end
                    OP_MULL_INT, OP_MULL_FLT: begin
                        ms_c = 1'b1;
                        if (MUL_LAT == 1) begin
                            // Single-cycle multiply retires immediately
                            w1_c = 1'b1;
                        end else begin
                            incr_c    = 1'b0;
                            stall_c   = 1'b1;
                            // Issue cycle counts as one; MUL_WAIT runs
                            // cnt down to 0 then retires.
                            cnt_nxt   = CW'(MUL_LAT - 2);
                            state_nxt = MUL_WAIT;
                        end
                    end
                    OP_BEQ, OP_BNE, OP_BGE, OP_BLO: begin
                        logic take;
                        take = 1'b0;
                        case (opcode)
                            OP_BEQ:  take =  flags[FLAG_Z];
                            OP_BNE:  take = !flags[FLAG_Z];
                            OP_BGE:  take = !flags[FLAG_N];
                            default: take =  flags[FLAG_C];
                        endcase
                        if (take) begin
                            incr_c = 1'b0;
                            rel_c  = 1'b1;
                        end
                    end
                    OP_WAITSW: begin
                        incr_c    = 1'b0;
                        stall_c   = 1'b1;
                        state_nxt = SW_PRESS;
                    end
                    default: ill_set = 1'b1;  // behaves as NOP
                endcase
            end

            MUL_WAIT: begin
                if (cnt == '0) begin
                    w1_c      = 1'b1;
                    incr_c    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    stall_c = 1'b1;
                    cnt_nxt = cnt - CW'(1);
                end
            end

            // A switch already held at issue must be seen released before
            // retiring, hence the separate press and release phases.
            SW_PRESS: begin
                stall_c = 1'b1;
                if (sw8_s) state_nxt = SW_RELEASE;
            end

            SW_RELEASE: begin
                if (!sw8_s) begin
                    incr_c    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    stall_c = 1'b1;
                end
            end

            default: state_nxt = RUN;
        endcase
    end

    // Controls are held inactive while reset is asserted
    assign PCincr      = nReset & incr_c;
    assign PCabsbranch = nReset & abs_c;
    assign PCrelbranch = nReset & rel_c;
    assign imm         = nReset & imm_c;
    assign w1          = nReset & w1_c;
    assign w2          = nReset & w2_c;
    assign mul_start   = nReset & ms_c;
    assign stall       = nReset & stall_c;
    assign illegal     = nReset & ill_q;
    assign ALUfunc     = opcode[ALUW-1:0];

endmodule
